// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory stage in front of the core.
package mem_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_WORD = 2'b01;
  localparam logic [1:0] RD_LO   = 2'b10;
  localparam logic [1:0] RD_HI   = 2'b11;

  // Narrow reads return the selected byte zero-extended into the low lane.
  function automatic logic [WORD_W-1:0] lane_select(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        sel);
    logic [WORD_W-1:0] res;
    case (sel)
      RD_LO:   res = {8'h00, word[7:0]};
      RD_HI:   res = {8'h00, word[15:8]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_loader_sp_ram.sv
// Single-port read-first RAM with a registered read port, suitable for block RAM.
module sp_ram
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Read and write share the edge; the read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_loader.sv
// Data memory stage: host-loaded RAM that then serves the core with one-cycle reads.
module data_mem_loader
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LOAD_WORDS = DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              start_out,
  input  logic [15:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              write_en,
  input  logic [1:0]        read_en,
  output logic [WORD_W-1:0] rdata,
  output logic              addr_err
);

  localparam int unsigned       ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        lane;
  logic              zero_out;
  logic              in_range;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_q;

  assign load_ready = (state == LOAD);

  always_comb begin
    in_range  = 32'(addr) < DEPTH;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == LOAD) begin
      ram_we    = load_valid;
      ram_addr  = ptr;
      ram_wdata = load_data;
    end else begin
      ram_en    = (read_en != RD_NONE) && in_range;
      ram_we    = write_en && in_range;
      ram_addr  = addr[ADDR_W-1:0];
      ram_wdata = wdata;
    end
  end

  sp_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clock(clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  // RAM output only advances on in-range reads; lane and zero flags are captured
  // alongside it so that rdata is stable between requests and zero after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD;
      ptr       <= '0;
      start_out <= 1'b0;
      zero_out  <= 1'b1;
      lane      <= RD_WORD;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          addr_err <= 1'b0;
          if (load_valid) begin
            ptr <= ptr + ADDR_W'(1);
            if (load_last || (ptr == LAST_IDX)) begin
              state     <= RUN;
              start_out <= 1'b1;
            end
          end
        end
        RUN: begin
          addr_err <= (write_en || (read_en != RD_NONE)) && !in_range;
          if (read_en != RD_NONE) begin
            lane     <= read_en;
            zero_out <= !in_range;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_comb begin
    rdata = zero_out ? '0 : lane_select(ram_q, lane);
  end

endmodule

// File: tb/tb_data_mem_loader.sv
// Self-checking bench for data_mem_loader: constant vector table, hand sequences, random run phase.
module tb_data_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        start_out;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        write_en;
  logic [1:0]  read_en;
  logic [15:0] rdata;
  logic        addr_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: plain array of words plus the value the core last saw.
  logic [15:0] mem_m [256];
  logic [15:0] rd_m;

  always #5 clock = ~clock;

  data_mem_loader #(
    .DEPTH     (256),
    .LOAD_WORDS(256)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .start_out (start_out),
    .addr      (addr),
    .wdata     (wdata),
    .write_en  (write_en),
    .read_en   (read_en),
    .rdata     (rdata),
    .addr_err  (addr_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    addr       = '0;
    wdata      = '0;
    write_en   = 1'b0;
    read_en    = 2'b00;
  endtask

  task automatic do_reset(input int unsigned cycles);
    idle_inputs();
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
    rd_m  = 16'h0000;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last, input logic [7:0] idx);
    check("load_ready_before_word", {15'd0, load_ready}, 16'd1);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    // core-side noise must be ignored while loading
    addr       = 16'($urandom_range(0, 400));
    write_en   = 1'($urandom);
    read_en    = 2'($urandom);
    tick();
    mem_m[idx] = d;
    idle_inputs();
    check("load_rdata_zero", rdata, 16'h0000);
    check("load_addr_err_low", {15'd0, addr_err}, 16'd0);
  endtask

  // Expected outputs from the access rules: byte reads via divide/modulo on the stored word.
  task automatic model_apply(input logic [15:0] a, input logic [15:0] wd, input logic we,
                             input logic [1:0] re, output logic [15:0] exp_rd,
                             output logic exp_err);
    int unsigned ai;
    bit inr;
    ai      = a;
    inr     = ai < 256;
    exp_err = (we || re != 2'b00) && !inr;
    if (re != 2'b00) begin
      if (!inr) rd_m = 16'h0000;
      else if (re == 2'b01) rd_m = mem_m[ai];
      else if (re == 2'b10) rd_m = 16'(int'(mem_m[ai]) % 256);
      else rd_m = 16'(int'(mem_m[ai]) / 256);
    end
    exp_rd = rd_m;
    if (we && inr) mem_m[ai] = wd;
  endtask

  task automatic core_access(input logic [15:0] a, input logic [15:0] wd, input logic we,
                             input logic [1:0] re);
    addr     = a;
    wdata    = wd;
    write_en = we;
    read_en  = re;
    tick();
    idle_inputs();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] wd;
    logic        we;
    logic [1:0]  re;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [15:0] er;
    logic        ee;
    logic [15:0] d;

    vecs[0]  = '{16'd0,     16'h0000, 1'b0, 2'b01, 16'h0003, 1'b0};
    vecs[1]  = '{16'd1,     16'h0000, 1'b0, 2'b01, 16'h0002, 1'b0};
    vecs[2]  = '{16'd2,     16'h0000, 1'b0, 2'b10, 16'h00CD, 1'b0};
    vecs[3]  = '{16'd2,     16'h0000, 1'b0, 2'b11, 16'h00AB, 1'b0};
    vecs[4]  = '{16'd7,     16'h0000, 1'b0, 2'b00, 16'h00AB, 1'b0};
    vecs[5]  = '{16'd5,     16'h1111, 1'b1, 2'b00, 16'h00AB, 1'b0};
    vecs[6]  = '{16'd5,     16'h0006, 1'b1, 2'b01, 16'h1111, 1'b0};
    vecs[7]  = '{16'd5,     16'h0000, 1'b0, 2'b01, 16'h0006, 1'b0};
    vecs[8]  = '{16'd44,    16'h4444, 1'b1, 2'b00, 16'h0006, 1'b0};
    vecs[9]  = '{16'd300,   16'h1234, 1'b1, 2'b00, 16'h0006, 1'b1};
    vecs[10] = '{16'd0,     16'h0000, 1'b0, 2'b00, 16'h0006, 1'b0};
    vecs[11] = '{16'd300,   16'h0000, 1'b0, 2'b01, 16'h0000, 1'b1};
    vecs[12] = '{16'd44,    16'h0000, 1'b0, 2'b01, 16'h4444, 1'b0};
    vecs[13] = '{16'd256,   16'h5555, 1'b1, 2'b00, 16'h4444, 1'b1};
    vecs[14] = '{16'd0,     16'h0000, 1'b0, 2'b01, 16'h0003, 1'b0};
    vecs[15] = '{16'd255,   16'hBEEF, 1'b1, 2'b00, 16'h0003, 1'b0};
    vecs[16] = '{16'd255,   16'h0000, 1'b0, 2'b11, 16'h00BE, 1'b0};
    vecs[17] = '{16'hFFFF,  16'h0000, 1'b0, 2'b10, 16'h0000, 1'b1};
    vecs[18] = '{16'd2,     16'h0000, 1'b0, 2'b00, 16'h0000, 1'b0};

    // Reset state
    do_reset(2);
    check("reset_start_out", {15'd0, start_out}, 16'd0);
    check("reset_load_ready", {15'd0, load_ready}, 16'd1);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_addr_err", {15'd0, addr_err}, 16'd0);

    // Full load with no load_last: automatic transition on index 255
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      load_word(d, 1'b0, 8'(i));
      check("full_load_start_out", {15'd0, start_out}, (i == 255) ? 16'd1 : 16'd0);
    end
    check("full_load_ready_low", {15'd0, load_ready}, 16'd0);

    // Short load with load_last; RAM survives reset
    do_reset(2);
    check("reload_start_low", {15'd0, start_out}, 16'd0);
    load_word(16'd3, 1'b0, 8'd0);
    load_word(16'd2, 1'b0, 8'd1);
    check("short_load_start_low", {15'd0, start_out}, 16'd0);
    load_word(16'hABCD, 1'b1, 8'd2);
    check("short_load_start_high", {15'd0, start_out}, 16'd1);
    check("short_load_ready_low", {15'd0, load_ready}, 16'd0);

    // Host pulses in RUN must not reach the RAM
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hDEAD;
      load_last  = 1'(i == 2);
      tick();
      idle_inputs();
    end
    check("run_ready_stays_low", {15'd0, load_ready}, 16'd0);
    check("run_start_held", {15'd0, start_out}, 16'd1);

    // Constant vector table
    for (int i = 0; i < 19; i++) begin
      model_apply(vecs[i].a, vecs[i].wd, vecs[i].we, vecs[i].re, er, ee);
      core_access(vecs[i].a, vecs[i].wd, vecs[i].we, vecs[i].re);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_addr_err", i), {15'd0, addr_err}, {15'd0, vecs[i].exp_err});
    end

    // Words 3 and 44-mirror check via model (3 came from the full load, untouched by DEAD pulses)
    model_apply(16'd3, 16'h0000, 1'b0, 2'b01, er, ee);
    core_access(16'd3, 16'h0000, 1'b0, 2'b01);
    check("run_load_pulses_ignored", rdata, er);

    // Randomized run phase against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      logic [15:0] wd;
      logic        we;
      logic [1:0]  re;
      a  = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(256, 65535));
      wd = 16'($urandom);
      we = ($urandom_range(0, 3) == 0);
      re = 2'($urandom);
      model_apply(a, wd, we, re, er, ee);
      core_access(a, wd, we, re);
      check("rand_rdata", rdata, er);
      check("rand_addr_err", {15'd0, addr_err}, {15'd0, ee});
    end

    // Reset mid-load: restarted pointer overwrites index 0 only
    do_reset(1);
    load_word(16'h7777, 1'b0, 8'd0);
    load_word(16'h8888, 1'b0, 8'd1);
    reset = 1'b1;
    tick();
    check("midload_reset_start_low", {15'd0, start_out}, 16'd0);
    check("midload_reset_ready", {15'd0, load_ready}, 16'd1);
    reset = 1'b0;
    rd_m  = 16'h0000;
    load_word(16'h9999, 1'b1, 8'd0);
    check("midload_start_high", {15'd0, start_out}, 16'd1);
    core_access(16'd0, 16'h0000, 1'b0, 2'b01);
    check("midload_mem0", rdata, 16'h9999);
    core_access(16'd1, 16'h0000, 1'b0, 2'b01);
    check("midload_mem1", rdata, 16'h8888);

    // Reset mid-run clears rdata and start_out
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_reset_rdata", rdata, 16'h0000);
    check("midrun_reset_start", {15'd0, start_out}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
